// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - Q1.14 types, saturation helper and scheduler state encoding
package lif_pkg;

  typedef logic signed [15:0] q14_t;
  typedef logic signed [31:0] acc_t;

  localparam int Q14_MAX = 32767;
  localparam int Q14_MIN = -32768;
  localparam int Q14_ONE = 16384;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CALC,
    ST_WR,
    ST_EMIT,
    ST_DONE
  } lif_state_e;

  // Clamp a wide accumulator into the Q1.14 representable range.
  function automatic q14_t sat_q14(input acc_t a);
    q14_t r;
    if (a > acc_t'(Q14_MAX)) begin
      r = q14_t'(Q14_MAX);
    end else if (a < acc_t'(Q14_MIN)) begin
      r = q14_t'(Q14_MIN);
    end else begin
      r = a[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lif_update_dp.sv
// rtl/lif_update_dp.sv - combinational leak, integrate, saturate and threshold
module lif_update_dp
  import lif_pkg::*;
#(
  parameter int LEAK_SHIFT = 4,
  parameter int V_TH       = Q14_ONE
) (
  input  q14_t v,
  input  q14_t i,
  output q14_t v_next,
  output logic spk
);

  acc_t v_ext;
  acc_t i_ext;
  acc_t sum;

  // Widen before the add so the overflow is visible to the clamp, then threshold the clamped value.
  always_comb begin
    v_ext  = acc_t'(v);
    i_ext  = acc_t'(i);
    sum    = v_ext + i_ext - (v_ext >>> LEAK_SHIFT);
    v_next = sat_q14(sum);
    spk    = (acc_t'(v_next) >= acc_t'(V_TH));
  end

endmodule

// File: rtl/lif_step_sched.sv
// rtl/lif_step_sched.sv - walks every neuron once per timestep through the shared LIF datapath
module lif_step_sched
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 64,
  parameter int AW         = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  parameter int LEAK_SHIFT = 4,
  parameter int V_TH       = Q14_ONE,
  parameter int V_RESET    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_start,
  output logic          step_busy,
  output logic          step_done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   v_rd_data,
  input  logic [15:0]   i_rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          spike_valid,
  input  logic          spike_ready,
  output logic [AW-1:0] spike_idx,
  output logic [AW:0]   spike_count
);

  localparam logic [AW-1:0] K_LAST  = AW'(N_NEURONS - 1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(N_NEURONS);

  lif_state_e      state_q, state_d;
  logic [AW-1:0]   k_q, k_d;
  q14_t            v_next_q, v_next_d;
  logic            spk_q, spk_d;
  logic [AW:0]     cnt_q, cnt_d;

  q14_t            v_rd_s;
  q14_t            i_rd_s;
  q14_t            dp_v_next;
  logic            dp_spk;
  logic            last_k;

  assign v_rd_s = v_rd_data;
  assign i_rd_s = i_rd_data;
  assign last_k = (k_q == K_LAST);

  lif_update_dp #(
    .LEAK_SHIFT (LEAK_SHIFT),
    .V_TH       (V_TH)
  ) u_dp (
    .v      (v_rd_s),
    .i      (i_rd_s),
    .v_next (dp_v_next),
    .spk    (dp_spk)
  );

  // State, neuron index, latched datapath result and spike counter; reset aborts a step outright.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      v_next_q <= '0;
      spk_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      v_next_q <= v_next_d;
      spk_q    <= spk_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and Moore outputs; address/data outputs read zero outside their strobe state.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    v_next_d    = v_next_q;
    spk_d       = spk_q;
    cnt_d       = cnt_q;
    step_done   = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    spike_valid = 1'b0;
    spike_idx   = '0;

    case (state_q)
      ST_IDLE: begin
        if (step_start) begin
          state_d = ST_RD;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
      ST_RD: begin
        rd_en   = 1'b1;
        rd_addr = k_q;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        v_next_d = dp_v_next;
        spk_d    = dp_spk;
        state_d  = ST_WR;
      end
      ST_WR: begin
        wr_en   = 1'b1;
        wr_addr = k_q;
        wr_data = spk_q ? q14_t'(V_RESET) : v_next_q;
        if (spk_q) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = ST_EMIT;
        end else if (last_k) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_RD;
        end
      end
      ST_EMIT: begin
        spike_valid = 1'b1;
        spike_idx   = k_q;
        if (spike_ready) begin
          if (last_k) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_RD;
          end
        end
      end
      ST_DONE: begin
        step_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign step_busy   = (state_q != ST_IDLE);
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_step_sched.sv
// tb/tb_lif_step_sched.sv - directed and randomized timesteps against an arithmetic LIF model
module tb_lif_step_sched;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          step_start;
  logic          step_busy;
  logic          step_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   v_rd_data;
  logic [15:0]   i_rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          spike_valid;
  logic          spike_ready;
  logic [AW-1:0] spike_idx;
  logic [AW:0]   spike_count;

  logic [15:0] v_mem [N];
  logic [15:0] i_mem [N];
  int          v_in  [N];
  int          i_in  [N];
  int          wr_a_log [$];
  int          wr_d_log [$];
  int          spk_log  [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  lif_step_sched #(
    .N_NEURONS  (N),
    .AW         (AW),
    .LEAK_SHIFT (4),
    .V_TH       (16384),
    .V_RESET    (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_start  (step_start),
    .step_busy   (step_busy),
    .step_done   (step_done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .v_rd_data   (v_rd_data),
    .i_rd_data   (i_rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_idx   (spike_idx),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      v_rd_data <= v_mem[rd_addr];
      i_rd_data <= i_mem[rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_next(input int v, input int i);
    int leak;
    int s;
    leak = (v < 0) ? -((-v + 15) / 16) : (v / 16);
    s = v + i - leak;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic logic [29:0] all_outs();
    return {step_busy, step_done, rd_en, rd_addr, wr_en, wr_addr, wr_data,
            spike_valid, spike_idx, spike_count};
  endfunction

  // mode: 0 ready always, 1 random ready, 2 ready low for 5 cycles on first spike
  task automatic run_step(input int mode, input bit poke_busy, input bit poke_done, input int abort_idx);
    int            n, stalls, held, vn, nspk, nw;
    int            exp_wd [N];
    int            exp_spk [$];
    logic [AW-1:0] prev_idx;
    bit            prev_stall, done_seen, aborted;

    exp_spk = {};
    for (int j = 0; j < N; j++) begin
      vn = model_next(v_in[j], i_in[j]);
      if (vn >= 16384) begin
        exp_spk.push_back(j);
        exp_wd[j] = 0;
      end else begin
        exp_wd[j] = vn & 32'hFFFF;
      end
      v_mem[j] = 16'(v_in[j]);
      i_mem[j] = 16'(i_in[j]);
    end
    wr_a_log = {};
    wr_d_log = {};
    spk_log  = {};
    n = 0; stalls = 0; held = 0;
    prev_stall = 1'b0; prev_idx = '0; done_seen = 1'b0; aborted = 1'b0;
    step_start = 1'b1;

    while (!done_seen && n < 600) begin
      @(negedge clk);
      n++;
      step_start = (poke_busy && n == 5);
      if (n == 1) begin
        chk("busy_after_start", step_busy, 1);
        chk("count_cleared", spike_count, 0);
      end
      if (prev_stall) chk("spike_hold", {spike_valid, spike_idx, rd_en}, {1'b1, prev_idx, 1'b0});
      if (abort_idx >= 0 && spike_valid && spike_idx == AW'(abort_idx)) begin
        aborted = 1'b1;
        break;
      end
      case (mode)
        0: spike_ready = 1'b1;
        1: spike_ready = 1'($urandom_range(0, 1));
        default: begin
          if (spike_valid && held < 5) begin
            spike_ready = 1'b0;
            held++;
          end else begin
            spike_ready = 1'b1;
          end
        end
      endcase
      if (wr_en) begin
        wr_a_log.push_back(int'(wr_addr));
        wr_d_log.push_back(int'(wr_data));
      end
      prev_stall = spike_valid && !spike_ready;
      prev_idx   = spike_idx;
      if (spike_valid && spike_ready) spk_log.push_back(int'(spike_idx));
      if (prev_stall) stalls++;
      if (step_done) begin
        done_seen = 1'b1;
        chk("busy_in_done", step_busy, 1);
        chk("spike_count", spike_count, exp_spk.size());
        step_start = poke_done;
      end
    end

    if (aborted) begin
      rst_n = 1'b0;
      spike_ready = 1'b0;
      @(negedge clk);
      chk("abort_outs_zero", all_outs(), 0);
      rst_n = 1'b1;
      repeat (8) begin
        @(negedge clk);
        chk("abort_quiet", {wr_en, step_done, step_busy}, 0);
      end
      chk("abort_nwr", wr_a_log.size(), abort_idx + 1);
      nw = (wr_a_log.size() < abort_idx + 1) ? wr_a_log.size() : abort_idx + 1;
      for (int j = 0; j < nw; j++) begin
        chk("abort_wr_addr", wr_a_log[j], j);
        chk("abort_wr_data", wr_d_log[j], exp_wd[j]);
      end
    end else begin
      chk("done_seen", done_seen, 1);
      chk("latency", n, 1 + 3 * N + exp_spk.size() + stalls);
      if (mode == 2 && exp_spk.size() > 0) chk("stall_cycles", stalls, 5);
      chk("nwr", wr_a_log.size(), N);
      nw = (wr_a_log.size() < N) ? wr_a_log.size() : N;
      for (int j = 0; j < nw; j++) begin
        chk("wr_addr", wr_a_log[j], j);
        chk("wr_data", wr_d_log[j], exp_wd[j]);
      end
      chk("nspk", spk_log.size(), exp_spk.size());
      nspk = (spk_log.size() < exp_spk.size()) ? spk_log.size() : exp_spk.size();
      for (int j = 0; j < nspk; j++) chk("spike_idx", spk_log[j], exp_spk[j]);
      @(negedge clk);
      step_start = 1'b0;
      chk("idle_busy", step_busy, 0);
      chk("idle_done", step_done, 0);
      chk("count_held", spike_count, exp_spk.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step_start = 1'b0;
    spike_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 0);

    for (int j = 0; j < N; j++) begin
      v_in[j] = 0;
      i_in[j] = 1000;
    end
    run_step(0, 1'b0, 1'b0, -1);

    v_in = '{20000, 16000, 5000, -3000};
    i_in = '{0, 1000, 200, -100};
    run_step(0, 1'b0, 1'b0, -1);

    v_in = '{32000, -32768, 100, -17};
    i_in = '{32000, -32768, 0, 0};
    run_step(0, 1'b0, 1'b0, -1);

    v_in = '{20000, 0, 20000, 0};
    i_in = '{0, 0, 0, 0};
    run_step(2, 1'b0, 1'b0, -1);

    v_in = '{20000, 20000, 20000, 20000};
    i_in = '{0, 0, 0, 0};
    run_step(1, 1'b1, 1'b1, -1);
    v_in = '{0, 100, -100, 30000};
    i_in = '{10, 0, 0, 0};
    run_step(0, 1'b0, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < N; j++) begin
        v_in[j] = int'($signed(16'($urandom)));
        i_in[j] = int'($signed(16'($urandom)));
      end
      run_step(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    v_in = '{0, 0, 20000, 20000};
    i_in = '{0, 0, 0, 0};
    run_step(0, 1'b0, 1'b0, 2);

    for (int j = 0; j < N; j++) begin
      v_in[j] = int'($signed(16'($urandom)));
      i_in[j] = 5000;
    end
    run_step(1, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lif_step_sched.md
Name:
lif_step_sched

Overview:
Time-step scheduler that sequences the shared Q1.14 LIF update datapath over all neurons held in the membrane RAM. On each step_start it walks neuron indices 0..N_NEURONS-1 and for each one: reads v and the accumulated input current i, computes the leaked and saturated next membrane value, thresholds it, writes back v_next or V_RESET, and emits the spike index through a valid/ready port. It sits between the network-level timestep controller and the membrane/current RAMs of the core.

Parameters:
N_NEURONS, 64, number of neurons per step (>=1)
AW, 6, address width, $clog2(N_NEURONS) (min 1)
LEAK_SHIFT, 4, leak = v >>> LEAK_SHIFT (arithmetic)
V_TH, 16384, spike threshold, signed Q1.14 (1.0)
V_RESET, 0, post-spike membrane value, signed Q1.14

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
step_start  in  1  start one timestep; sampled only in IDLE
step_busy  out  1  high from the cycle after start is accepted until DONE inclusive
step_done  out  1  one-cycle pulse at end of step
rd_en  out  1  RAM read strobe
rd_addr  out  AW  read index
v_rd_data  in  16  membrane, signed Q1.14, valid the cycle after rd_en
i_rd_data  in  16  input current, signed Q1.14, same timing as v_rd_data
wr_en  out  1  membrane write strobe
wr_addr  out  AW  write index
wr_data  out  16  signed Q1.14 write value
spike_valid  out  1  spike index available
spike_ready  in  1  consumer accepts spike
spike_idx  out  AW  index of spiking neuron
spike_count  out  AW+1  spikes in current/last step; cleared when a step starts

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, index k=0, all strobes/valid/done/busy = 0, rd_addr/wr_addr/wr_data/spike_idx = 0, spike_count = 0. Reset mid-step aborts immediately: no further writes or spikes and no done pulse.
- States: IDLE -> RD -> CALC -> WR -> (EMIT) -> RD or DONE -> IDLE.
- IDLE: on step_start=1 -> RD, k=0, spike_count=0. step_start in any other state is ignored (not queued).
- RD: rd_en=1, rd_addr=k, for one cycle -> CALC.
- CALC: RAM data valid. Sign-extend v and i to 32 bits; sum = v + i - (v >>> LEAK_SHIFT); v_next = saturate(sum) to [-32768, 32767]; spk = (v_next >= V_TH), signed compare. Register v_next and spk -> WR.
- WR: wr_en=1 for exactly one cycle, wr_addr=k, wr_data = spk ? V_RESET : v_next. If spk: spike_count++ -> EMIT. Otherwise -> DONE if k==N_NEURONS-1, else k++ -> RD.
- EMIT: spike_valid=1, spike_idx=k, held stable until spike_ready=1. On handshake -> DONE or RD with k+1, same rule as WR. spike_ready while spike_valid=0 has no effect.
- DONE: step_done=1 for one cycle -> IDLE. A step_start in the cycle after DONE is accepted.
- Latency: with no spikes, start accepted at cycle T gives step_done at T+1+3*N_NEURONS. Each spike adds 1 + (cycles spike_ready is held low).
- Exactly one write per neuron per step. Writes are strictly in ascending index order. k never wraps past N_NEURONS-1.
- N_NEURONS=1: a single RD/CALC/WR pass, then DONE.
- spike_count saturates at N_NEURONS (cannot exceed it by construction).

Decomposition:
- Package lif_pkg: typedef q14_t (logic signed [15:0]), typedef acc_t (logic signed [31:0]), constants Q14_MAX=32767, Q14_MIN=-32768, Q14_ONE=16384, function sat_q14(acc_t)->q14_t. Also the state enum.
- Sub-module lif_update_dp, purely combinational: inputs v, i; outputs v_next, spk. It is parameterised by LEAK_SHIFT and V_TH, uses sat_q14, and is instantiated once in the scheduler.

Test Plan:
1. N=4, all v=0, i=1000, spike_ready=1, start at T -> RAM holds 1000 at idx 0..3, no spike_valid, step_done at T+13, spike_count=0.
2. idx0 v=20000, i=0 -> leak 1250, v_next=18750 >= 16384 -> wr_data=0, spike_idx=0, spike_count=1. idx1 v=16000, i=1000 -> 16000 written, no spike.
3. Saturation: v=32000, i=32000 -> sum 62000, wr_data=0 with spike (clamped 32767). v=-32768, i=-32768 -> sum -63488, wr_data=-32768, no spike.
4. Backpressure: two spiking neurons, spike_ready low for 5 cycles on the first -> spike_valid/spike_idx stable, no RD issued meanwhile. The second spike follows in order, and done is delayed exactly 5+2 cycles versus the no-spike case.
5. step_start pulsed while busy, and in the DONE cycle -> ignored, no restart, k unaffected. A start in the cycle after DONE begins a new step with spike_count cleared.
6. rst_n low during EMIT of idx 2 -> next cycle IDLE, all outputs 0, no further wr_en or step_done. A subsequent start performs a full clean step from idx 0.
